// File: rtl/switch_port_arbiter.sv
// Packet-level round-robin arbiter for one switch output port.
// A grant is held from the grant edge until the beat flagged in_last is accepted.
// The winner scan starts just above the last finished input, so that input is
// lowest priority.
// Optional build macro SWITCH_ARB_WATCHDOG_EN adds a stall watchdog.
// When the watchdog fires, it force-releases a grant after TIMEOUT stalled cycles.
module switch_port_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] in_valid,
  input  logic [NUM_REQ-1:0] in_last,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic [NUM_REQ-1:0] in_ready,
  output logic               out_valid,
  output logic               pkt_done,
  output logic               timeout
);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     scan_base;
  logic [ID_W-1:0]     scan_idx;
  logic [ID_W-1:0]     win_id;
  logic                any_req;
  logic                xfer;
  logic                last;
  logic                wd_fire;

  // Datapath handshake derived from the registered grant
  always_comb begin
    in_ready  = gnt & {NUM_REQ{out_ready}};
    out_valid = |(gnt & in_valid);
    xfer      = out_valid & out_ready;
    last      = xfer & in_last[gnt_id];
    any_req   = |req;
  end

  // Re-arbitration on the last beat must already treat the finishing input as
  // lowest priority, before rr_ptr has been updated.
  always_comb begin
    scan_base = (state == StXfer) ? gnt_id : rr_ptr;
  end

  // Winner: first set req bit scanning upward from scan_base+1, wrapping
  always_comb begin
    win_id   = '0;
    scan_idx = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((int'(scan_base) + k) % NUM_REQ);
      if (req[scan_idx]) begin
        win_id = scan_idx;
      end
    end
  end

`ifdef SWITCH_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] stall_cnt;

  // Fire on the stall cycle that would bring the counter up to TIMEOUT
  always_comb begin
    wd_fire = (state == StXfer) && !xfer && (stall_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Stall counter: cleared while idle (covers every fresh grant) and on each beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == StIdle || xfer || wd_fire) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Registered one-cycle timeout pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= wd_fire;
    end
  end
`else
  // No watchdog: a grant is held indefinitely
  always_comb begin
    wd_fire = 1'b0;
    timeout = 1'b0;
  end
`endif

  // Arbitration FSM with registered grant and packet-done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      gnt      <= '0;
      gnt_id   <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (any_req) begin
            state  <= StXfer;
            gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
            gnt_id <= win_id;
          end
        end
        StXfer: begin
          if (last) begin
            pkt_done <= 1'b1;
            rr_ptr   <= gnt_id;
            if (any_req) begin
              gnt    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
              gnt_id <= win_id;
            end else begin
              state  <= StIdle;
              gnt    <= '0;
              gnt_id <= '0;
            end
          end else if (wd_fire) begin
            rr_ptr <= gnt_id;
            state  <= StIdle;
            gnt    <= '0;
            gnt_id <= '0;
          end
        end
        default: begin
          state  <= StIdle;
          gnt    <= '0;
          gnt_id <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Directed self-checking bench for switch_port_arbiter (NUM_REQ=4, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
module tb_switch_port_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] in_valid = '0;
  logic [3:0] in_last = '0;
  logic       out_ready = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] in_ready;
  logic       out_valid;
  logic       pkt_done;
  logic       timeout;

  int vectors = 0;
  int miscompares = 0;

  switch_port_arbiter #(
    .NUM_REQ(4),
    .ID_W   (2),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .in_valid (in_valid),
    .in_last  (in_last),
    .out_ready(out_ready),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .pkt_done (pkt_done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_grant: gnt=%b gnt_id=%0d, required gnt=0000 gnt_id=0", gnt, gnt_id);
    end
    vectors++;
    if (pkt_done !== 1'b0 || timeout !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: pkt_done=%b timeout=%b out_valid=%b in_ready=%b, required all 0",
               pkt_done, timeout, out_valid, in_ready);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    req = 4'b0001; in_valid = 4'b0001; out_ready = 1'b1; in_last = '0;
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_latency: gnt=%b, required 0000", gnt);
    end
    tick();
    req = '0;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001 || in_ready !== 4'b0001 || out_valid !== 1'b1 || pkt_done !== 1'b0) begin
        miscompares++;
        $display("FAIL single_beat%0d: gnt=%b in_ready=%b out_valid=%b pkt_done=%b, required 0001 0001 1 0",
                 b, gnt, in_ready, out_valid, pkt_done);
      end
      tick();
    end
    in_valid = '0; in_last = '0;
    @(negedge clk);
    vectors++;
    if (pkt_done !== 1'b1 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_done: pkt_done=%b gnt=%b, required 1 0000", pkt_done, gnt);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (pkt_done !== 1'b0 || gnt !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_after: pkt_done=%b gnt=%b, required 0 0000", pkt_done, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (gnt !== exp_gnt[i] || gnt_id !== exp_id[i] || pkt_done !== (i > 0)) begin
        miscompares++;
        $display("FAIL rr_cycle%0d: gnt=%b gnt_id=%0d pkt_done=%b, required %b %0d %b",
                 i, gnt, gnt_id, pkt_done, exp_gnt[i], exp_id[i], (i > 0));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int beats = 0;
    do_reset();
    req = 4'b0100;
    tick();
    req = '0; in_valid = 4'b0100; in_last = '0;
    for (int i = 0; i < 4; i++) begin
      out_ready = pat[i];
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0100 || in_ready !== (pat[i] ? 4'b0100 : 4'b0000) || pkt_done !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: gnt=%b in_ready=%b pkt_done=%b, required 0100 %b 0",
                 i, gnt, in_ready, pkt_done, (pat[i] ? 4'b0100 : 4'b0000));
      end
      if (out_valid && in_ready[2]) beats++;
      tick();
    end
    vectors++;
    if (beats != 2) begin
      miscompares++;
      $display("FAIL stall_beats: counted %0d, required 2", beats);
    end
    out_ready = 1'b1; in_last = 4'b0100;
    tick();
    in_valid = '0; in_last = '0;
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0000 || pkt_done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_end: gnt=%b pkt_done=%b, required 0000 1", gnt, pkt_done);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0010;
    tick();
    // Input 1 drops req; input 3 requests and shows a stray valid/last that must be ignored
    req = 4'b1000; in_valid = 4'b1010; in_last = 4'b1000; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) in_last = 4'b1010;
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0010 || pkt_done !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_hold%0d: gnt=%b pkt_done=%b, required 0010 0", i, gnt, pkt_done);
      end
      tick();
    end
    in_valid = '0; in_last = '0;
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || pkt_done !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_switch: gnt=%b gnt_id=%0d pkt_done=%b, required 1000 3 1",
               gnt, gnt_id, pkt_done);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req = 4'b0010;
    tick();
    req = '0;
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL midrst_pre: gnt=%b, required 0010", gnt);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_async: gnt=%b gnt_id=%0d, required 0000 0", gnt, gnt_id);
    end
    tick();
    reset = 1'b0; req = 4'b1111;
    tick();
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_regrant: gnt=%b gnt_id=%0d, required 0001 0", gnt, gnt_id);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 4'b0001; in_valid = '0; out_ready = 1'b1;
    tick();
    req = '0;
`ifdef SWITCH_ARB_WATCHDOG_EN
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL wd_stall%0d: gnt=%b timeout=%b, required 0001 0", c, gnt, timeout);
      end
      tick();
    end
    req = 4'b0011;
    @(negedge clk);
    vectors++;
    if (timeout !== 1'b1 || gnt !== 4'b0000 || pkt_done !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_fire: timeout=%b gnt=%b pkt_done=%b, required 1 0000 0",
               timeout, gnt, pkt_done);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (timeout !== 1'b0 || gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL wd_regrant: timeout=%b gnt=%b, required 0 0010", timeout, gnt);
    end
`else
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      vectors++;
      if (gnt !== 4'b0001 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_stall%0d: gnt=%b timeout=%b, required 0001 0", c, gnt, timeout);
      end
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_stall();
    test_req_drop();
    test_reset_mid_packet();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
